// File: rtl/clkdiv_ctrl.sv
// Programmable clock divider: one-cycle tick plus 50%-duty output clock, divisor from two prioritised requesters.
// Latency: tick/outputclock registered; first tick N edges after enable; divisor changes take effect at a period boundary.
// Backpressure: both ready signals drop while a divisor is pending; requester 1 also yields whenever requester 0 is valid.
module clkdiv_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 50000
) (
    input  logic             inputclock,
    input  logic             rst,
    input  logic             enable,
    input  logic             cfg0_valid,
    input  logic [WIDTH-1:0] cfg0_div,
    output logic             cfg0_ready,
    input  logic             cfg1_valid,
    input  logic [WIDTH-1:0] cfg1_div,
    output logic             cfg1_ready,
    output logic             tick,
    output logic             outputclock,
    output logic [WIDTH-1:0] cur_div,
    output logic             cfg_err,
    output logic             pending
);

    localparam logic [WIDTH-1:0] DEF_DIV = DEFAULT_DIV[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [WIDTH-1:0] cur_div_q,  cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             tick_q,     tick_d;
    logic             oclk_q,     oclk_d;
    logic             err_q,      err_d;

    logic             acc0;
    logic             acc1;
    logic             acc;
    logic             acc_nz;
    logic [WIDTH-1:0] acc_div;
    logic             wrap;

    // Handshake and arbitration: requester 0 always wins a simultaneous offer.
    always_comb begin
        cfg0_ready = (state_q != PEND);
        cfg1_ready = (state_q != PEND) && !cfg0_valid;
        acc0       = cfg0_valid && cfg0_ready;
        acc1       = cfg1_valid && cfg1_ready;
        acc        = acc0 || acc1;
        acc_div    = acc0 ? cfg0_div : cfg1_div;
        acc_nz     = acc && (acc_div != '0);
        wrap       = (count_q == (cur_div_q - ONE));
    end

    // Next-state: period counting, boundary-aligned divisor updates, enable/disable.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        tick_d     = 1'b0;
        oclk_d     = oclk_q;
        err_d      = acc && (acc_div == '0);

        case (state_q)
            IDLE: begin
                count_d = '0;
                oclk_d  = 1'b0;
                // Nothing is running, so a new divisor can take effect at once.
                if (acc_nz) begin
                    cur_div_d = acc_div;
                end
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN, PEND: begin
                if (!enable) begin
                    state_d = IDLE;
                    count_d = '0;
                    oclk_d  = 1'b0;
                    // Stopping is a boundary too: commit whatever was waiting.
                    if (state_q == PEND) begin
                        cur_div_d = pend_div_q;
                    end else if (acc_nz) begin
                        cur_div_d = acc_div;
                    end
                end else begin
                    if (wrap) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                        oclk_d  = ~oclk_q;
                    end else begin
                        count_d = count_q + ONE;
                    end
                    if ((state_q == PEND) && wrap) begin
                        cur_div_d = pend_div_q;
                        state_d   = RUN;
                    end
                    // An accept on a wrap edge still waits for the following wrap.
                    if ((state_q == RUN) && acc_nz) begin
                        pend_div_d = acc_div;
                        state_d    = PEND;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge inputclock) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            cur_div_q  <= DEF_DIV;
            pend_div_q <= DEF_DIV;
            tick_q     <= 1'b0;
            oclk_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            tick_q     <= tick_d;
            oclk_q     <= oclk_d;
            err_q      <= err_d;
        end
    end

    assign tick        = tick_q;
    assign outputclock = oclk_q;
    assign cur_div     = cur_div_q;
    assign cfg_err     = err_q;
    assign pending     = (state_q == PEND);

endmodule
